cordic_vectoring_iterative: RTL and testbench



---
 rtl/cordic_vectoring_iterative.sv | 184 ++++++++++++++++++
 tb/tb_cordic_vectoring_iterative.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/cordic_vectoring_iterative.sv
// Iterative vectoring-mode CORDIC (circular coordinates).
// Takes a Cartesian vector (x, y) and returns its gain-compensated magnitude
// and its angle (atan2) in units of pi. A single add/shift slice is reused
// for every micro-rotation. The unit accepts one strobe while idle and
// answers with a one-cycle result strobe.
module cordic_vectoring_iterative #(
   parameter int N_FRAC     = 7,
   parameter int ITERATIONS = 6
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  logic signed [N_FRAC:0]   x_i,
   input  logic signed [N_FRAC:0]   y_i,
   input  logic                     data_in_valid_strobe_i,
   output logic signed [N_FRAC:0]   magnitude_o,
   output logic signed [N_FRAC:0]   angle_o,
   output logic                     busy_o,
   output logic                     data_out_valid_strobe_o
);

   localparam int W  = N_FRAC + 1;            // external word width
   localparam int XW = N_FRAC + 3;            // x/y: room for negation, CORDIC gain and sqrt2
   localparam int ZW = N_FRAC + 2;            // z: room for +/-pi/2 plus accumulated table
   localparam int CW = $clog2(ITERATIONS);

   localparam logic [CW-1:0]        LAST_ITER = CW'(ITERATIONS - 1);
   localparam logic signed [ZW-1:0] Z_HALF_PI = ZW'(2 ** (N_FRAC - 1));
   localparam logic signed [XW-1:0] MAG_MAX   = XW'(2 ** N_FRAC - 1);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_CALC   = 2'd1,
      S_OUTPUT = 2'd2
   } state_t;

   state_t                 state_q, state_d;
   logic signed [XW-1:0]   x_q, x_d;
   logic signed [XW-1:0]   y_q, y_d;
   logic signed [ZW-1:0]   z_q, z_d;
   logic [CW-1:0]          cnt_q, cnt_d;
   logic                   zero_q, zero_d;
   logic signed [W-1:0]    mag_q, mag_d;
   logic signed [W-1:0]    angle_q, angle_d;
   logic                   valid_q, valid_d;

   logic signed [XW-1:0]   x_ext;
   logic signed [XW-1:0]   y_ext;
   logic signed [XW-1:0]   x_sh;
   logic signed [XW-1:0]   y_sh;
   logic signed [ZW-1:0]   atan_val;
   logic signed [XW-1:0]   mag_full;

   // Arctangent table, atan(2^-i)/pi in Q0.7.
   function automatic logic signed [ZW-1:0] atan_lut(input logic [CW-1:0] idx);
      case (idx)
         CW'(0):  atan_lut = ZW'(32);
         CW'(1):  atan_lut = ZW'(18);
         CW'(2):  atan_lut = ZW'(9);
         CW'(3):  atan_lut = ZW'(5);
         CW'(4):  atan_lut = ZW'(2);
         CW'(5):  atan_lut = ZW'(1);
         default: atan_lut = '0;
      endcase
   endfunction

   assign x_ext    = {{(XW - W){x_i[W-1]}}, x_i};
   assign y_ext    = {{(XW - W){y_i[W-1]}}, y_i};
   assign x_sh     = x_q >>> cnt_q;
   assign y_sh     = y_q >>> cnt_q;
   assign atan_val = atan_lut(cnt_q);
   // x/1.647 approximated as x*(1/2 + 1/8 - 1/64)
   assign mag_full = (x_q >>> 1) + (x_q >>> 3) - (x_q >>> 6);

   // Next-state and datapath: capture with pre-rotation, iterate, then publish.
   always_comb begin
      // NOTE: every signal gets its hold value first so no path can infer a latch.
      state_d = state_q;
      x_d     = x_q;
      y_d     = y_q;
      z_d     = z_q;
      cnt_d   = cnt_q;
      zero_d  = zero_q;
      mag_d   = mag_q;
      angle_d = angle_q;
      valid_d = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (data_in_valid_strobe_i) begin
               cnt_d  = '0;
               zero_d = (x_i == '0) && (y_i == '0);
               // Fold left half-plane inputs into the right half-plane so the
               // micro-rotations only need to cover +/-pi/2.
               if (!x_i[W-1]) begin
                  x_d = x_ext;
                  y_d = y_ext;
                  z_d = '0;
               end else if (!y_i[W-1]) begin
                  x_d = y_ext;
                  y_d = -x_ext;
                  z_d = Z_HALF_PI;
               end else begin
                  x_d = -y_ext;
                  y_d = x_ext;
                  z_d = -Z_HALF_PI;
               end
               state_d = S_CALC;
            end
         end

         S_CALC: begin
            // Rotate toward the x axis; both updates read the old x and y.
            if (!y_q[XW-1]) begin
               x_d = x_q + y_sh;
               y_d = y_q - x_sh;
               z_d = z_q + atan_val;
            end else begin
               x_d = x_q - y_sh;
               y_d = y_q + x_sh;
               z_d = z_q - atan_val;
            end
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == LAST_ITER) begin
               state_d = S_OUTPUT;
            end
         end

         S_OUTPUT: begin
            if (zero_q) begin
               mag_d   = '0;
               angle_d = '0;
            end else begin
               if (mag_full[XW-1]) begin
                  mag_d = '0;
               end else if (mag_full > MAG_MAX) begin
                  mag_d = MAG_MAX[W-1:0];
               end else begin
                  mag_d = mag_full[W-1:0];
               end
               // +pi and -pi share one code; the wrap is intentional.
               angle_d = z_q[W-1:0];
            end
            valid_d = 1'b1;
            state_d = S_IDLE;
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // State and datapath registers with synchronous active-low reset.
   always_ff @(posedge clk_i) begin
      // NOTE: registers take <= so every flop samples pre-edge values.
      if (!rst_i) begin
         state_q <= S_IDLE;
         x_q     <= '0;
         y_q     <= '0;
         z_q     <= '0;
         cnt_q   <= '0;
         zero_q  <= 1'b0;
         mag_q   <= '0;
         angle_q <= '0;
         valid_q <= 1'b0;
      end else begin
         state_q <= state_d;
         x_q     <= x_d;
         y_q     <= y_d;
         z_q     <= z_d;
         cnt_q   <= cnt_d;
         zero_q  <= zero_d;
         mag_q   <= mag_d;
         angle_q <= angle_d;
         valid_q <= valid_d;
      end
   end

   assign magnitude_o             = mag_q;
   assign angle_o                 = angle_q;
   assign busy_o                  = (state_q != S_IDLE);
   assign data_out_valid_strobe_o = valid_q;

endmodule

// File: tb/tb_cordic_vectoring_iterative.sv
// Directed testbench for the iterative vectoring CORDIC: reset, hand-worked
// vectors, quadrant folding, saturation, handshake timing and an angle sweep.
module tb_cordic_vectoring_iterative;

   localparam int N_FRAC     = 7;
   localparam int ITERATIONS = 6;
   localparam int A_TAB[6]   = '{32, 18, 9, 5, 2, 1};

   logic                    clk = 1'b0;
   logic                    rst = 1'b0;
   logic signed [N_FRAC:0]  x   = '0;
   logic signed [N_FRAC:0]  y   = '0;
   logic                    strb = 1'b0;
   logic signed [N_FRAC:0]  mag_o;
   logic signed [N_FRAC:0]  ang_o;
   logic                    busy;
   logic                    vld;

   int total = 0;
   int bad   = 0;

   cordic_vectoring_iterative #(
      .N_FRAC     (N_FRAC),
      .ITERATIONS (ITERATIONS)
   ) dut (
      .clk_i                   (clk),
      .rst_i                   (rst),
      .x_i                     (x),
      .y_i                     (y),
      .data_in_valid_strobe_i  (strb),
      .magnitude_o             (mag_o),
      .angle_o                 (ang_o),
      .busy_o                  (busy),
      .data_out_valid_strobe_o (vld)
   );

   always #5 clk = ~clk;

   // Compare with optional tolerance; wrap folds the difference mod 256.
   task automatic check(input string tag, input int got, input int exp,
                        input int tol = 0, input bit wrap = 1'b0);
      int diff;
      diff = got - exp;
      if (wrap) diff = (((diff % 256) + 256 + 128) % 256) - 128;
      total++;
      if (diff > tol || diff < -tol) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d (tol %0d)", tag, got, exp, tol);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Independent reference of the vectoring algorithm on plain integers.
   function automatic void model(input int xv, input int yv, output int m, output int a);
      int xr, yr, zr, xt;
      if (xv == 0 && yv == 0) begin
         m = 0;
         a = 0;
         return;
      end
      if (xv >= 0) begin
         xr = xv;  yr = yv;  zr = 0;
      end else if (yv >= 0) begin
         xr = yv;  yr = -xv; zr = 64;
      end else begin
         xr = -yv; yr = xv;  zr = -64;
      end
      for (int i = 0; i < ITERATIONS; i++) begin
         xt = xr;
         if (yr >= 0) begin
            xr = xr + (yr >>> i);
            yr = yr - (xt >>> i);
            zr = zr + A_TAB[i];
         end else begin
            xr = xr - (yr >>> i);
            yr = yr + (xt >>> i);
            zr = zr - A_TAB[i];
         end
      end
      m = (xr >>> 1) + (xr >>> 3) - (xr >>> 6);
      if (m > 127) m = 127;
      if (m < 0)   m = 0;
      a = int'(byte'(zr));
   endfunction

   // One transaction: strobe, wait for the result pulse, check latency and width.
   task automatic run(input string tag, input int xv, input int yv,
                      output int m, output int a);
      int lat;
      x    = 8'(xv);
      y    = 8'(yv);
      strb = 1'b1;
      tick();
      strb = 1'b0;
      lat  = -1;
      for (int i = 1; i <= 20; i++) begin
         tick();
         if (vld) begin
            lat = i;
            break;
         end
      end
      m = int'(mag_o);
      a = int'(ang_o);
      check({tag, ".lat"}, lat, 7);
      tick();
      check({tag, ".pulse"}, int'(vld), 0);
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int m, a, lat, cnt, em, ea;
      real th;

      // Reset state
      tick();
      tick();
      check("rst.mag",   int'(mag_o), 0);
      check("rst.ang",   int'(ang_o), 0);
      check("rst.busy",  int'(busy), 0);
      check("rst.valid", int'(vld), 0);
      rst = 1'b1;
      tick();

      // Origin and simple axes
      run("zero", 0, 0, m, a);
      check("zero.mag", m, 0);
      check("zero.ang", a, 0);
      run("x64", 64, 0, m, a);
      check("x64.mag", m, 65);
      check("x64.ang", a, 1);
      run("y100", 0, 100, m, a);
      check("y100.mag", m, 100, 3);
      check("y100.ang", a, 64, 2, 1'b1);

      // Quadrant folding
      run("q3", -64, -64, m, a);
      check("q3.mag", m, 91, 3);
      check("q3.ang", a, -96, 2, 1'b1);
      run("q2pi", -100, 1, m, a);
      check("q2pi.mag", m, 100, 3);
      check("q2pi.ang", a, 127, 2, 1'b1);
      run("q3pi", -100, -1, m, a);
      check("q3pi.ang", a, -128, 2, 1'b1);

      // Saturation
      run("satn", -128, -128, m, a);
      check("satn.mag", m, 127);
      check("satn.ang", a, -96, 2, 1'b1);
      run("satp", 127, 127, m, a);
      check("satp.mag", m, 127);
      check("satp.ang", a, 32, 2, 1'b1);

      // Strobe at E3 is ignored: result belongs to the first vector only
      x = 8'sd64; y = 8'sd0; strb = 1'b1;
      tick();                               // E0
      strb = 1'b0;
      tick();                               // E1
      tick();                               // E2
      x = 8'sd0; y = 8'sd100; strb = 1'b1;
      tick();                               // E3
      strb = 1'b0;
      check("e3.busy", int'(busy), 1);
      lat = -1;
      for (int i = 4; i <= 20; i++) begin
         tick();
         if (vld) begin
            lat = i;
            break;
         end
      end
      check("e3.lat", lat, 7);
      check("e3.mag", int'(mag_o), 65);
      check("e3.ang", int'(ang_o), 1);
      cnt = 0;
      for (int i = 0; i < 12; i++) begin
         tick();
         if (vld) cnt++;
      end
      check("e3.extra", cnt, 0);

      // Back-to-back: new strobe sampled at E8 is accepted
      x = 8'sd64; y = 8'sd0; strb = 1'b1;
      tick();                               // E0
      strb = 1'b0;
      lat = -1;
      for (int i = 1; i <= 20; i++) begin
         tick();
         if (vld) begin
            lat = i;
            break;
         end
      end
      check("b2b.lat1", lat, 7);
      check("b2b.mag1", int'(mag_o), 65);
      x = -8'sd64; y = -8'sd64; strb = 1'b1;
      tick();                               // E8 of first = E0 of second
      strb = 1'b0;
      check("b2b.busy", int'(busy), 1);
      lat = -1;
      for (int i = 1; i <= 20; i++) begin
         tick();
         if (vld) begin
            lat = i;
            break;
         end
      end
      check("b2b.lat2", lat, 7);
      check("b2b.mag2", int'(mag_o), 91, 3);
      check("b2b.ang2", int'(ang_o), -96, 2, 1'b1);
      tick();

      // Reset mid-CALC discards the in-flight result
      run("pre", 64, 0, m, a);
      check("pre.mag", m, 65);
      x = 8'sd127; y = 8'sd127; strb = 1'b1;
      tick();                               // E0
      strb = 1'b0;
      tick();                               // E1
      tick();                               // E2
      check("mid.busy", int'(busy), 1);
      rst = 1'b0;
      tick();
      rst = 1'b1;
      check("mid.mag",   int'(mag_o), 0);
      check("mid.ang",   int'(ang_o), 0);
      check("mid.busy0", int'(busy), 0);
      check("mid.valid", int'(vld), 0);
      cnt = 0;
      for (int i = 0; i < 12; i++) begin
         tick();
         if (vld) cnt++;
      end
      check("mid.extra", cnt, 0);

      // Sweep 256 angles at radius 100 against the reference model
      for (int k = 0; k < 256; k++) begin
         int xv, yv;
         th = 2.0 * 3.14159265358979 * real'(k) / 256.0;
         xv = int'(100.0 * $cos(th));
         yv = int'(100.0 * $sin(th));
         model(xv, yv, em, ea);
         run($sformatf("sw%0d", k), xv, yv, m, a);
         check($sformatf("sw%0d.mag", k), m, em);
         check($sformatf("sw%0d.ang", k), a, ea, 0, 1'b1);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
